// File: rtl/lcd_pixel_packer.sv
// Packs 1/2/4/8/16/24-bpp pixels LSB-first into 32-bit words for the LCD pixel FIFO.
// Optional zero-padded partial-word flush is compiled in with LCD_PACKER_FLUSH_EN.
module lcd_pixel_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  lcdbpp,
    input  logic        startpipe,
    input  logic [23:0] pixel,
    input  logic        pixel_valid,
    output logic        stall,
    input  logic        flush,
    output logic [31:0] fifo_data,
    output logic        write,
    input  logic        full
);

`ifdef LCD_PACKER_FLUSH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
    logic unused_flush;
    assign unused_flush = flush;
`endif

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] data_nxt;
    logic        out_valid, out_valid_nxt;

    logic [23:0] mask;
    logic [4:0]  shift;
    logic [4:0]  last_slot;
    logic [31:0] packed_word;
    logic        in_flush;
    logic        accept;
    logic        complete;

    always_comb begin
        mask      = 24'hFFFF;
        shift     = {cnt[0], 4'd0};
        last_slot = 5'd1;
        case (lcdbpp)
            3'b000: begin mask = 24'h000001; shift = cnt;               last_slot = 5'd31; end
            3'b001: begin mask = 24'h000003; shift = {cnt[3:0], 1'b0}; last_slot = 5'd15; end
            3'b010: begin mask = 24'h00000F; shift = {cnt[2:0], 2'b0}; last_slot = 5'd7;  end
            3'b011: begin mask = 24'h0000FF; shift = {cnt[1:0], 3'b0}; last_slot = 5'd3;  end
            3'b101: begin mask = 24'hFFFFFF; shift = 5'd0;             last_slot = 5'd0;  end
            default: ;
        endcase
    end

`ifdef LCD_PACKER_FLUSH_EN
    assign in_flush = (state == FLUSH);
`else
    assign in_flush = 1'b0;
`endif

    assign stall       = (out_valid & full) | in_flush;
    assign write       = out_valid & ~full;
    assign accept      = startpipe & pixel_valid & ~stall;
    assign complete    = accept & (cnt == last_slot);
    assign packed_word = acc | ({8'd0, pixel & mask} << shift);

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        data_nxt      = fifo_data;
        out_valid_nxt = out_valid & full;

        if (complete) begin
            data_nxt      = packed_word;
            out_valid_nxt = 1'b1;
            acc_nxt       = 32'd0;
            cnt_nxt       = 5'd0;
        end else if (accept) begin
            acc_nxt = packed_word;
            cnt_nxt = cnt + 5'd1;
        end

        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
`ifdef LCD_PACKER_FLUSH_EN
                // a pixel arriving with the flush is packed first and then flushed
                if (flush && !complete && (cnt != 5'd0 || accept))
                    state_nxt = FLUSH;
`endif
            end
`ifdef LCD_PACKER_FLUSH_EN
            FLUSH: begin
                if (!out_valid) begin
                    data_nxt      = acc;
                    out_valid_nxt = 1'b1;
                    acc_nxt       = 32'd0;
                    cnt_nxt       = 5'd0;
                    state_nxt     = RUN;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // dropping startpipe discards any partial word; a completed word stays pending
        if (!startpipe) begin
            state_nxt = IDLE;
            acc_nxt   = 32'd0;
            cnt_nxt   = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= 5'd0;
            fifo_data <= 32'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            fifo_data <= data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_packer.sv
// Directed bench for lcd_pixel_packer; flush checks follow LCD_PACKER_FLUSH_EN.
// A posedge monitor logs every FIFO write so word order and spacing can be checked.
module tb_lcd_pixel_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  lcdbpp;
    logic        startpipe;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        stall;
    logic        flush;
    logic [31:0] fifo_data;
    logic        write;
    logic        full;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq[$];
    int          wt[$];
    int          cyc_cnt   = 0;
    int          stall_cnt = 0;
    int          base;
    int          sc;

    lcd_pixel_packer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lcdbpp      (lcdbpp),
        .startpipe   (startpipe),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .stall       (stall),
        .flush       (flush),
        .fifo_data   (fifo_data),
        .write       (write),
        .full        (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (write) begin
            wq.push_back(fifo_data);
            wt.push_back(cyc_cnt);
        end
        if (stall)
            stall_cnt <= stall_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] p);
        pixel       = p;
        pixel_valid = 1'b1;
        cyc();
        pixel_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        lcdbpp      = 3'b011;
        startpipe   = 1'b0;
        pixel       = 24'd0;
        pixel_valid = 1'b0;
        flush       = 1'b0;
        full        = 1'b0;
        #1;
        chk("rst_data",  fifo_data, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        startpipe = 1'b1;
        cyc();

        // 8 bpp basic word
        base = wq.size();
        push(24'h11); push(24'h22); push(24'h33);
        chk("b8_nowrite", {31'd0, write}, 32'd0);
        push(24'h44);
        #4;
        chk("b8_write", {31'd0, write}, 32'd1);
        chk("b8_data",  fifo_data, 32'h44332211);
        cyc();
        chk("b8_count", wq.size() - base, 32'd1);
        chk("b8_write_clr", {31'd0, write}, 32'd0);

        // 1 bpp, upper pixel bits ignored
        lcdbpp = 3'b000;
        base   = wq.size();
        for (int i = 0; i < 32; i++) begin
            pixel       = (i % 2 == 0) ? 24'hFFFFFF : 24'hFFFFFE;
            pixel_valid = 1'b1;
            cyc();
        end
        pixel_valid = 1'b0;
        #4;
        chk("b1_write", {31'd0, write}, 32'd1);
        chk("b1_data",  fifo_data, 32'h55555555);
        cyc();
        chk("b1_count", wq.size() - base, 32'd1);

        // 24 bpp back-to-back, one word per clock
        lcdbpp = 3'b101;
        base   = wq.size();
        sc     = stall_cnt;
        push(24'hABCDEF);
        push(24'h123456);
        #4;
        chk("b24_write", {31'd0, write}, 32'd1);
        chk("b24_data2", fifo_data, 32'h00123456);
        cyc();
        chk("b24_count", wq.size() - base, 32'd2);
        if (wq.size() - base == 2) begin
            chk("b24_w0", wq[base], 32'h00ABCDEF);
            chk("b24_w1", wq[base+1], 32'h00123456);
            chk("b24_spacing", wt[base+1] - wt[base], 32'd1);
        end
        chk("b24_nostall", stall_cnt - sc, 32'd0);

        // 16 bpp backpressure
        lcdbpp = 3'b110;
        base   = wq.size();
        full   = 1'b1;
        pixel  = 24'h1111; pixel_valid = 1'b1;
        cyc();
        pixel  = 24'h2222;
        cyc();
        pixel  = 24'h3333;
        #4;
        chk("b16_stall",   {31'd0, stall}, 32'd1);
        chk("b16_nowrite", {31'd0, write}, 32'd0);
        repeat (3) cyc();
        chk("b16_held_cnt",   wq.size() - base, 32'd0);
        chk("b16_held_data",  fifo_data, 32'h22221111);
        chk("b16_held_stall", {31'd0, stall}, 32'd1);
        full = 1'b0;
        #4;
        chk("b16_rel_stall", {31'd0, stall}, 32'd0);
        chk("b16_rel_write", {31'd0, write}, 32'd1);
        cyc();
        pixel = 24'h4444;
        cyc();
        pixel_valid = 1'b0;
        #4;
        chk("b16_write2", {31'd0, write}, 32'd1);
        chk("b16_data2",  fifo_data, 32'h44443333);
        cyc();
        chk("b16_count", wq.size() - base, 32'd2);
        if (wq.size() - base == 2) begin
            chk("b16_w0", wq[base], 32'h22221111);
            chk("b16_w1", wq[base+1], 32'h44443333);
        end

        // 4 bpp flush behaviour
        lcdbpp = 3'b010;
        base   = wq.size();
        sc     = stall_cnt;
        push(24'h1); push(24'h2); push(24'h3);
`ifdef LCD_PACKER_FLUSH_EN
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #4;
        chk("fl_stall",   {31'd0, stall}, 32'd1);
        chk("fl_nowrite", {31'd0, write}, 32'd0);
        cyc();
        #4;
        chk("fl_stall_clr", {31'd0, stall}, 32'd0);
        chk("fl_write",     {31'd0, write}, 32'd1);
        chk("fl_data",      fifo_data, 32'h00000321);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (3) cyc();
        chk("fl_count", wq.size() - base, 32'd1);
        chk("fl_stall_cycles", stall_cnt - sc, 32'd1);
`else
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #4;
        chk("nf_nowrite", {31'd0, write}, 32'd0);
        chk("nf_nostall", {31'd0, stall}, 32'd0);
        cyc();
        push(24'h4); push(24'h5); push(24'h6); push(24'h7); push(24'h8);
        #4;
        chk("nf_write", {31'd0, write}, 32'd1);
        chk("nf_data",  fifo_data, 32'h87654321);
        cyc();
        chk("nf_count", wq.size() - base, 32'd1);
`endif

        // asynchronous reset with a pending word
        lcdbpp = 3'b011;
        full   = 1'b1;
        push(24'h01); push(24'h02); push(24'h03); push(24'h04);
        #4;
        chk("ar_stall", {31'd0, stall}, 32'd1);
        base = wq.size();
        full = 1'b0;
        #1;
        chk("ar_write_pre", {31'd0, write}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_write", {31'd0, write}, 32'd0);
        chk("ar_stall0", {31'd0, stall}, 32'd0);
        chk("ar_data", fifo_data, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc();
        push(24'hA1); push(24'hA2); push(24'hA3); push(24'hA4);
        #4;
        chk("ar_fresh_write", {31'd0, write}, 32'd1);
        chk("ar_fresh_data",  fifo_data, 32'hA4A3A2A1);
        cyc();
        chk("ar_count", wq.size() - base, 32'd1);
        if (wq.size() - base == 1)
            chk("ar_w0", wq[base], 32'hA4A3A2A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
